conv2d_stream: RTL and testbench

Parametrised streaming 2-D convolution engine. It is the next generation of the fixed 28×28, 3×3 convolution datapath: a K×K kernel and any H×W frame, with a valid/ready pixel input and a valid/ready result output. Internally it has line buffers, a pipelined multiply/adder tree, optional ReLU and signed saturation. It sits between the image source and the products/feature-map store, and it takes weights over a serial load port.

---
 rtl/conv2d_stream.sv | 210 +++++++++++++++++++++
 tb/tb_conv2d_stream.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming KxK stride-1 convolution over an HxW frame.
// Line buffers feed a pipelined multiply / adder tree with ReLU and saturation.
module conv2d_stream #(
    parameter int H  = 28,
    parameter int W  = 28,
    parameter int K  = 3,
    parameter int DW = 8,
    parameter int KW = 8,
    parameter int OW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          relu_en,
    input  logic          wt_valid,
    input  logic [KW-1:0] wt_data,
    input  logic          pix_valid,
    output logic          pix_ready,
    input  logic [DW-1:0] pix_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam int NT    = K * K;
    localparam int PW    = DW + KW + 1;
    localparam int ACC_W = DW + KW + 1 + $clog2(K * K);
    localparam int SRL   = (K - 1) * W + K;
    localparam int RW    = (H > 1) ? $clog2(H) : 1;
    localparam int CW    = (W > 1) ? $clog2(W) : 1;
    localparam int IW    = (NT > 1) ? $clog2(NT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic signed [KW-1:0]    wt_q [NT];
    logic [IW-1:0]           wt_idx_q;
    logic [RW-1:0]           row_q;
    logic [CW-1:0]           col_q;
    logic                    relu_q;
    logic [DW-1:0]           sr_q [SRL];
    logic                    v0_q, l0_q, v1_q, l1_q, v2_q, l2_q;
    logic signed [PW-1:0]    prod_q [NT];
    logic signed [PW-1:0]    prod_d [NT];
    logic signed [ACC_W-1:0] sum_q, sum_d, rl;
    logic signed [OW-1:0]    sat;
    logic                    out_valid_q, out_last_q, done_q;
    logic [OW-1:0]           out_data_q;
    logic                    stall, accept, hs_last, last_pix, win_ok;
    logic                    en1, en2, en3;

    // A full output register blocks the pipe; empty stages still advance.
    assign stall    = out_valid_q && !out_ready;
    assign en3      = !stall;
    assign en2      = en3 || !v2_q;
    assign en1      = en2 || !v1_q;
    assign accept   = (state_q == RUN) && pix_valid && !stall;
    assign hs_last  = out_valid_q && out_ready && out_last_q;
    assign last_pix = (row_q == RW'(H - 1)) && (col_q == CW'(W - 1));
    assign win_ok   = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign done      = done_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (accept && last_pix) state_d = DRAIN;
            DRAIN:   if (hs_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        pix_ready = (state_q == RUN) && !stall;
        busy      = (state_q != IDLE);
    end

    // Serial weight load, row-major, index wraps after the last tap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NT; i++) wt_q[i] <= '0;
            wt_idx_q <= '0;
        end else if (state_q == IDLE && wt_valid) begin
            wt_q[wt_idx_q] <= wt_data;
            wt_idx_q <= (wt_idx_q == IW'(NT - 1)) ? '0 : wt_idx_q + IW'(1);
        end
    end

    // Raster position counters and per-frame ReLU mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q  <= '0;
            col_q  <= '0;
            relu_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            row_q  <= '0;
            col_q  <= '0;
            relu_q <= relu_en;
        end else if (accept) begin
            if (col_q == CW'(W - 1)) begin
                col_q <= '0;
                row_q <= row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    // Line buffers plus window as one shift chain; contents need no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            sr_q[0] <= pix_data;
            for (int i = 1; i < SRL; i++) sr_q[i] <= sr_q[i-1];
        end
    end

    // Window tap (a,b) sits (K-1-a) rows and (K-1-b) pixels behind the newest
    always_comb begin
        for (int a = 0; a < K; a++) begin
            for (int b = 0; b < K; b++) begin
                prod_d[a*K+b] = PW'($signed({1'b0, sr_q[(K-1-a)*W + (K-1-b)]})
                                    * wt_q[a*K+b]);
            end
        end
    end

    // Adder tree over the registered products
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NT; i++) sum_d = sum_d + ACC_W'(prod_q[i]);
    end

    // ReLU on the full-precision sum
    always_comb begin
        rl = (relu_q && sum_q[ACC_W-1]) ? '0 : sum_q;
    end

    if (OW < ACC_W) begin : g_sat
        localparam logic signed [ACC_W-1:0] SMAX =
            {{(ACC_W-OW+1){1'b0}}, {(OW-1){1'b1}}};
        localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;
        // Clamp into the signed output range
        always_comb begin
            if (rl > SMAX)      sat = SMAX[OW-1:0];
            else if (rl < SMIN) sat = SMIN[OW-1:0];
            else                sat = rl[OW-1:0];
        end
    end else begin : g_ext
        assign sat = OW'(rl);
    end

    // Pipeline: window valid, products, sum, output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q <= 1'b0; l0_q <= 1'b0;
            v1_q <= 1'b0; l1_q <= 1'b0;
            v2_q <= 1'b0; l2_q <= 1'b0;
            for (int i = 0; i < NT; i++) prod_q[i] <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (accept) begin
                v0_q <= win_ok;
                l0_q <= last_pix;
            end else if (en1) begin
                v0_q <= 1'b0;
                l0_q <= 1'b0;
            end
            if (en1) begin
                v1_q <= v0_q;
                l1_q <= l0_q;
                for (int i = 0; i < NT; i++) prod_q[i] <= prod_d[i];
            end
            if (en2) begin
                v2_q  <= v1_q;
                l2_q  <= l1_q;
                sum_q <= sum_d;
            end
            if (en3) begin
                out_valid_q <= v2_q;
                out_last_q  <= l2_q;
                out_data_q  <= sat;
            end
        end
    end

    // One-cycle completion pulse after the final result is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done_q <= 1'b0;
        else        done_q <= (state_q == DRAIN) && hs_last;
    end

endmodule

// File: tb/tb_conv2d_stream.sv
// tb_conv2d_stream: directed frames on a 5x5 image with a 3x3 kernel,
// scoreboard of expected results, second instance with a 12-bit output.
module tb_conv2d_stream;

    localparam int H = 5;
    localparam int W = 5;
    localparam int K = 3;
    localparam int DW = 8;
    localparam int KW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic relu_en = 1'b0;
    logic wt_valid = 1'b0;
    logic [KW-1:0] wt_data = '0;
    logic pix_valid = 1'b0;
    logic [DW-1:0] pix_data = '0;
    logic out_ready = 1'b1;

    logic pix_ready, out_valid, out_last, busy, done;
    logic [15:0] out_data;
    logic pix_ready12, out_valid12, out_last12, busy12, done12;
    logic [11:0] out_data12;

    conv2d_stream #(.H(H), .W(W), .K(K), .DW(DW), .KW(KW), .OW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .relu_en(relu_en),
        .wt_valid(wt_valid), .wt_data(wt_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    conv2d_stream #(.H(H), .W(W), .K(K), .DW(DW), .KW(KW), .OW(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .start(start), .relu_en(relu_en),
        .wt_valid(wt_valid), .wt_data(wt_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready12), .pix_data(pix_data),
        .out_valid(out_valid12), .out_ready(out_ready), .out_data(out_data12),
        .out_last(out_last12), .busy(busy12), .done(done12)
    );

    always #5 clk = ~clk;

    int pix [H*W];
    int w [K*K];
    int q16 [$];
    int q12 [$];
    int checks = 0;
    int passes = 0;
    int fails = 0;
    int cyc = 0;
    bit rnd_rdy = 1'b0;
    int first_cyc = -1;
    int acc_cyc = -1;
    bit done_seen = 1'b0;
    bit pend_done = 1'b0;
    bit pend_after = 1'b0;
    bit held = 1'b0;
    logic [15:0] held_d;
    logic [11:0] held_d12;
    logic held_l;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int ow);
        int mx, mn;
        mx = (1 << (ow - 1)) - 1;
        mn = -(1 << (ow - 1));
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    function automatic int model(input int r, input int c, input bit relu);
        int s;
        s = 0;
        for (int a = 0; a < K; a++)
            for (int b = 0; b < K; b++)
                s += pix[(r + a) * W + (c + b)] * w[a * K + b];
        if (relu && s < 0) s = 0;
        return s;
    endfunction

    // Output monitor: scoreboard pops, stall stability, done pulse shape
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            if (pend_done) begin
                chk("done_pulse", done, 1);
                chk("busy_after_done", busy, 0);
                pend_done = 1'b0;
                pend_after = 1'b1;
                done_seen = 1'b1;
            end else if (pend_after) begin
                chk("done_width", done, 0);
                pend_after = 1'b0;
            end else if (done) begin
                chk("spurious_done", done, 0);
            end
            if (held) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, held_d);
                chk("hold_data12", out_data12, held_d12);
                chk("hold_last", out_last, held_l);
            end
            held = 1'b0;
            if (out_valid && !out_ready) begin
                chk("stall_pix_ready", pix_ready, 0);
                held = 1'b1;
                held_d = out_data;
                held_d12 = out_data12;
                held_l = out_last;
            end
            if (out_valid && out_ready) begin
                if (q16.size() == 0) begin
                    chk("unexpected_out", out_valid, 0);
                end else begin
                    chk("data16", $signed(out_data), q16.pop_front());
                    chk("data12", $signed(out_data12), q12.pop_front());
                    chk("valid12", out_valid12, 1);
                    chk("last", out_last, q16.size() == 0);
                    if (out_last) pend_done = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic load_w(input int n);
        for (int i = 0; i < n; i++) begin
            wt_valid = 1'b1;
            wt_data = KW'(w[i]);
            tick();
        end
        wt_valid = 1'b0;
    endtask

    task automatic run_frame(input bit relu, input bit rnd, input int npix,
                             input bit noise, input bit wstart, input bit lat);
        int idx, bud;
        bit acc;
        if (npix == H * W) begin
            for (int r = 0; r <= H - K; r++)
                for (int c = 0; c <= W - K; c++) begin
                    q16.push_back(sat(model(r, c, relu), 16));
                    q12.push_back(sat(model(r, c, relu), 12));
                end
        end
        done_seen = 1'b0;
        first_cyc = -1;
        acc_cyc = -1;
        rnd_rdy = rnd;
        relu_en = relu;
        start = 1'b1;
        if (wstart) begin
            wt_valid = 1'b1;
            wt_data = KW'(w[K*K-1]);
        end
        tick();
        start = 1'b0;
        wt_valid = 1'b0;
        relu_en = ~relu;
        idx = 0;
        bud = 0;
        while (idx < npix && bud < 2000) begin
            pix_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            pix_data = DW'(pix[idx]);
            start = noise && idx >= 5 && idx < 15;
            wt_valid = start;
            wt_data = KW'($urandom_range(0, 255));
            @(negedge clk);
            acc = pix_valid && pix_ready;
            if (acc && idx == (K - 1) * W + (K - 1)) acc_cyc = cyc;
            tick();
            if (acc) idx++;
            bud++;
        end
        pix_valid = 1'b0;
        start = 1'b0;
        wt_valid = 1'b0;
        chk("pixels_accepted", idx, npix);
        if (npix == H * W) begin
            bud = 0;
            while (!done_seen && bud < 400) begin
                tick();
                bud++;
            end
            chk("frame_done", done_seen, 1);
            chk("queue_empty", q16.size(), 0);
            if (lat) chk("latency", first_cyc - acc_cyc - 1, 3);
            rnd_rdy = 1'b0;
            tick();
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_pix_ready", pix_ready, 0);
        chk("idle_busy", busy, 0);

        // all ones: nine results of 9, latency check
        for (int i = 0; i < K * K; i++) w[i] = 1;
        for (int i = 0; i < H * W; i++) pix[i] = 1;
        load_w(K * K);
        run_frame(1'b0, 1'b0, H * W, 1'b0, 1'b0, 1'b1);

        // identity kernel over a ramp: 6,7,8,11,12,13,16,17,18
        for (int i = 0; i < K * K; i++) w[i] = (i == 4) ? 1 : 0;
        for (int i = 0; i < H * W; i++) pix[i] = i;
        load_w(K * K);
        run_frame(1'b0, 1'b0, H * W, 1'b0, 1'b0, 1'b0);

        // negative saturation: -2295 / -2048, then ReLU to 0
        for (int i = 0; i < K * K; i++) w[i] = -1;
        for (int i = 0; i < H * W; i++) pix[i] = 255;
        load_w(K * K);
        run_frame(1'b0, 1'b0, H * W, 1'b0, 1'b0, 1'b0);
        run_frame(1'b1, 1'b0, H * W, 1'b0, 1'b0, 1'b0);

        // ramp identity with random ready and valid gaps
        for (int i = 0; i < K * K; i++) w[i] = (i == 4) ? 1 : 0;
        for (int i = 0; i < H * W; i++) pix[i] = i;
        load_w(K * K);
        run_frame(1'b0, 1'b1, H * W, 1'b0, 1'b0, 1'b0);

        // random weights and pixels under random handshakes
        for (int i = 0; i < K * K; i++) w[i] = int'($urandom_range(0, 255)) - 128;
        for (int i = 0; i < H * W; i++) pix[i] = int'($urandom_range(0, 255));
        load_w(K * K);
        run_frame(1'b0, 1'b1, H * W, 1'b0, 1'b0, 1'b0);
        run_frame(1'b1, 1'b1, H * W, 1'b0, 1'b0, 1'b0);

        // abort after 10 pixels with a mid-cycle reset
        for (int i = 0; i < K * K; i++) w[i] = 1;
        load_w(K * K);
        run_frame(1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0);
        chk("busy_before_abort", busy, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_pix_ready", pix_ready, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_done", done, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // weights were cleared by reset: all results 0
        for (int i = 0; i < K * K; i++) w[i] = 0;
        run_frame(1'b0, 1'b0, H * W, 1'b0, 1'b0, 1'b0);

        // reload, last weight together with start; start/wt noise in RUN
        for (int i = 0; i < K * K; i++) w[i] = (i == 4) ? 1 : 0;
        w[0] = -2;
        w[8] = 3;
        for (int i = 0; i < H * W; i++) pix[i] = i * 10;
        load_w(K * K - 1);
        run_frame(1'b0, 1'b1, H * W, 1'b1, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
